// File: rtl/qmac_pkg.sv
// Shared constants and types for the quantization MAC input path.
package qmac_pkg;

  localparam int ACC_W = 28;

  localparam logic [2:0] MODE_S1  = 3'd1;
  localparam logic [2:0] MODE_S2  = 3'd2;
  localparam logic [2:0] MODE_S3  = 3'd3;
  localparam logic [2:0] MODE_S4  = 3'd4;
  localparam logic [2:0] MODE_S5  = 3'd5;
  localparam logic [2:0] MODE_DEF = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Modes 1..5 select their own shift; anything else falls back to 6.
  function automatic logic [2:0] shift_of(input logic [2:0] mode);
    logic [2:0] sh;
    case (mode)
      MODE_S1, MODE_S2, MODE_S3, MODE_S4, MODE_S5: sh = mode;
      default:                                     sh = 3'd6;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/inport.sv
// Combinational int8 alignment stage: zero-extend and left-shift by mode.
module inport
  import qmac_pkg::*;
#(
  parameter int OUT_W = 28
) (
  input  logic [7:0]       data,
  input  logic [2:0]       mode,
  output logic [OUT_W-1:0] aligned
);

  logic [OUT_W-1:0] ext;

  assign ext     = {{(OUT_W-8){1'b0}}, data};
  assign aligned = ext << shift_of(mode);

endmodule

// File: rtl/inport_acc_ctrl.sv
// Sequences a vector of int8 samples through inport and accumulates the aligned sum;
// one sample per cycle, result held on out_sum/out_valid until out_ready.
module inport_acc_ctrl #(
  parameter int ACC_W = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       cfg_len,
  input  logic [2:0]       cfg_mode,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);
  import qmac_pkg::*;

  state_t           state;
  logic [8:0]       count;
  logic [2:0]       mode;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] aligned;

  inport #(.OUT_W(ACC_W)) u_inport (
    .data    (in_data),
    .mode    (mode),
    .aligned (aligned)
  );

  assign out_sum = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      count     <= 9'd0;
      mode      <= MODE_DEF;
      acc       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            // A length of 0 encodes a full 256-sample vector.
            count    <= (cfg_len == 8'd0) ? 9'd256 : {1'b0, cfg_len};
            mode     <= cfg_mode;
            acc      <= '0;
            state    <= ST_RUN;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          if (in_valid && in_ready) begin
            acc   <= acc + aligned;
            count <= count - 9'd1;
            if (count == 9'd1) begin
              state     <= ST_DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inport_acc_ctrl.sv
// Directed bench for inport_acc_ctrl with hand-computed sums.
module tb_inport_acc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  cfg_len;
  logic [2:0]  cfg_mode;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [27:0] out_sum;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;
  int beats;

  always #5 clk = ~clk;

  inport_acc_ctrl #(.ACC_W(28)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_len   (cfg_len),
    .cfg_mode  (cfg_mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_sum   (out_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [7:0] len, input logic [2:0] md);
    start    = 1'b1;
    cfg_len  = len;
    cfg_mode = md;
    tick();
    start    = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_len = 8'd0; cfg_mode = 3'd0;
    in_data = 8'd0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_out_sum", {4'd0, out_sum}, 32'd0);

    // len=4, mode=2, samples 1..4 -> (1+2+3+4)<<2 = 40
    cmd(8'd4, 3'd2);
    chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    beat(8'd1); beat(8'd2); beat(8'd3);
    chk("t1_not_done", {31'd0, out_valid}, 32'd0);
    beat(8'd4);
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("t1_sum", {4'd0, out_sum}, 32'd40);
    accept();
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);
    chk("t1_idle_valid", {31'd0, out_valid}, 32'd0);

    // len=0 (256), mode=0 (shift 6), all 255 -> 256*16320
    cmd(8'd0, 3'd0);
    beats = 0;
    in_data  = 8'd255;
    in_valid = 1'b1;
    for (int i = 0; i < 300 && !out_valid; i++) begin
      if (in_ready) beats++;
      tick();
    end
    in_valid = 1'b0;
    chk("t2_beats", beats, 32'd256);
    chk("t2_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_sum", {4'd0, out_sum}, 32'd4177920);
    accept();

    // len=3, mode=5, sample 7 with bubbles -> 3*224 = 672
    cmd(8'd3, 3'd5);
    beat(8'd7);
    chk("t3_sum_b1", {4'd0, out_sum}, 32'd224);
    tick();
    chk("t3_bubble1", {4'd0, out_sum}, 32'd224);
    beat(8'd7);
    chk("t3_sum_b2", {4'd0, out_sum}, 32'd448);
    tick();
    chk("t3_bubble2", {4'd0, out_sum}, 32'd448);
    chk("t3_bubble_busy", {31'd0, out_valid}, 32'd0);
    beat(8'd7);
    chk("t3_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_sum", {4'd0, out_sum}, 32'd672);

    // DONE held 5 cycles with a start pulse mid-wait
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        start = 1'b1; cfg_len = 8'd1; cfg_mode = 3'd3;
      end
      tick();
      start = 1'b0;
      chk("t4_hold_sum", {4'd0, out_sum}, 32'd672);
      chk("t4_hold_valid", {31'd0, out_valid}, 32'd1);
    end
    // start on the accepting cycle is also ignored
    start = 1'b1;
    accept();
    start = 1'b0;
    chk("t4_idle_busy", {31'd0, busy}, 32'd0);
    chk("t4_idle_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t4_idle_sum", {4'd0, out_sum}, 32'd672);

    // reset mid-run discards partial sum and the concurrent sample
    cmd(8'd8, 3'd1);
    beat(8'd5); beat(8'd5); beat(8'd5);
    chk("t5_partial", {4'd0, out_sum}, 32'd30);
    rst = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_sum", {4'd0, out_sum}, 32'd0);
    chk("t5_rst_in_ready", {31'd0, in_ready}, 32'd0);
    cmd(8'd1, 3'd1);
    beat(8'd9);
    chk("t5_valid", {31'd0, out_valid}, 32'd1);
    chk("t5_sum", {4'd0, out_sum}, 32'd18);
    out_ready = 1'b1;  // held high from here; no effect before DONE
    tick();

    // mode 6 and mode 7 both shift by 6
    cmd(8'd1, 3'd6);
    chk("t6_ready_hold", {31'd0, busy}, 32'd1);
    in_data = 8'd1; in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("t6_mode6", {4'd0, out_sum}, 32'd64);
    accept();
    cmd(8'd1, 3'd7);
    cfg_mode = 3'd1;
    beat(8'd1);
    chk("t6_mode7", {4'd0, out_sum}, 32'd64);
    accept();

    // cfg_mode change between beats leaves the latched mode in force
    cmd(8'd2, 3'd6);
    beat(8'd1);
    cfg_mode = 3'd1;
    cfg_len  = 8'd5;
    beat(8'd1);
    chk("t6_mid_valid", {31'd0, out_valid}, 32'd1);
    chk("t6_mid_sum", {4'd0, out_sum}, 32'd128);
    accept();
    chk("t6_end_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/inport_acc_ctrl.md
# inport_acc_ctrl

Sequencer for the int8 input path of the quantization MAC. It accepts a start command carrying a vector length and an alignment mode. It then streams that many int8 samples through one `inport` alignment stage under a valid/ready handshake and accumulates the 28-bit aligned values. The finished sum is presented to the downstream MAC stage with a valid/ready handshake.

## Interface
Parameters:
- `ACC_W`, default 28: accumulator and result width; must equal the `inport` output width.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `start`  in  1  command strobe; sampled only in IDLE.
- `cfg_len`  in  8  number of samples in the vector; 0 encodes 256.
- `cfg_mode`  in  3  `inport` alignment mode; latched on start.
- `in_data`  in  8  unsigned int8 sample.
- `in_valid`  in  1  sample valid.
- `in_ready`  out  1  sample accepted when `in_valid & in_ready`.
- `out_sum`  out  ACC_W  accumulated result.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `busy`  out  1  high in every state other than IDLE.

## Operation
- States:
  - IDLE: `in_ready=0`, `out_valid=0`, `busy=0`.
    - `start=1` latches `cfg_len` into the remaining-count register (0 becomes 256).
    - `start=1` latches `cfg_mode` into the mode register.
    - `start=1` clears the accumulator and moves to RUN.
  - RUN: `in_ready=1`.
    - Each handshake adds the `inport` output, computed from `in_data` and the latched mode, to the accumulator and decrements the remaining count.
    - The handshake that takes the count from 1 to 0 moves to DONE.
  - DONE: `out_valid=1`, `in_ready=0`, `out_sum` equals the accumulator and is stable.
    - `out_ready=1` returns to IDLE.
- `start` while `busy` is ignored; it is not queued.
- `cfg_len` and `cfg_mode` changes after the start cycle have no effect on the running vector.
- Alignment: the sample is zero-extended and left-shifted by the mode.
  - Modes 1..5 shift by 1..5.
  - Modes 0, 6 and 7 shift by 6.
- Width: the maximum per-sample value is 255<<6 = 16320, so the maximum sum is 256 × 16320 = 4,177,920 < 2^28. The block has no overflow and no saturation logic.
- `in_valid` low during RUN inserts bubbles. The accumulator and count hold.
- `out_ready` held high before DONE has no effect.

## Timing
- Reset values: `in_ready=0`, `out_valid=0`, `busy=0`, `out_sum=0`. State is IDLE, count 0, mode register 6.
- `start` at cycle t puts the block in RUN with `in_ready=1` at t+1.
- Throughput is one sample per cycle. The `inport` alignment is combinational in front of the accumulator adder.
- Latency: the last sample accepted at cycle t gives `out_valid=1` at t+1.
- The `out_ready` handshake at cycle u gives IDLE at u+1.
  - A `start` at u is ignored, because the block is not yet in IDLE.
  - The earliest accepted restart is at u+1.
  - The minimum command-to-command period is therefore len + 2 cycles.
- `rst` asserted in any state:
  - Next cycle the block is in IDLE with the reset values above.
  - A partial sum is discarded.
  - A sample presented in the same cycle as `rst` is not counted.
- `out_valid` stays high and `out_sum` stays constant until accepted. There is no timeout.

## Structure
- Shared package `qmac_pkg` holds:
  - `ACC_W` (28).
  - Mode constants `MODE_S1`..`MODE_S5` and `MODE_DEF`=6.
  - State encoding `ST_IDLE`/`ST_RUN`/`ST_DONE` (2 bits).
- The existing `inport` module is instantiated once as the only sub-module. The controller must not re-implement the shift.
- The controller RTL contains:
  - the FSM,
  - a 9-bit remaining counter,
  - a 3-bit mode register,
  - the ACC_W accumulator.

## Test plan
- Reset, then start with len=4, mode=2, samples 1, 2, 3, 4 back-to-back → `out_valid` one cycle after the 4th beat, `out_sum`=40.
- Start with len=0, mode=0, all samples 255 → exactly 256 beats accepted, `out_sum`=4,177,920. This checks the 256 encoding and the default mode.
- Start with len=3, mode=5, `in_valid` toggling 1/0/1/0/1 with samples 7 → `out_sum`=672; count unchanged in bubble cycles.
- DONE with `out_ready`=0 for 5 cycles and a `start` pulse mid-wait → `out_sum` stable, `start` ignored; `out_ready`=1 returns to IDLE next cycle.
- Start with len=8, mode=1, assert `rst` after 3 beats → next cycle IDLE, `out_sum`=0, `busy`=0. A new len=1, mode=1, sample 9 then gives 18.
- Modes 6 and 7 with sample 1 → both give `out_sum`=64. Changing `cfg_mode` mid-RUN does not alter the result.
